// File: rtl/host_stream_if.sv
// Device-side endpoint of the host streaming link. It deserializes one host pass into the
// ifmap/weight/bias SRAM write ports, then drains the ofmap SRAM back to the host.
module host_stream_if #(
  parameter int DATA_W       = 32,
  parameter int IFMAP_WORDS  = 16,
  parameter int WEIGHT_WORDS = 1024,
  parameter int BIAS_WORDS   = 64,
  parameter int OFMAP_WORDS  = 64,
  localparam int IF_AW = $clog2(IFMAP_WORDS),
  localparam int W_AW  = $clog2(WEIGHT_WORDS),
  localparam int B_AW  = $clog2(BIAS_WORDS),
  localparam int O_AW  = $clog2(OFMAP_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              compute_done,
  output logic              ifmap_we,
  output logic [IF_AW-1:0]  ifmap_addr,
  output logic              weight_we,
  output logic [W_AW-1:0]   weight_addr,
  output logic              bias_we,
  output logic [B_AW-1:0]   bias_addr,
  output logic [DATA_W-1:0] wdata,
  output logic              load_done,
  output logic              ofmap_re,
  output logic [O_AW-1:0]   ofmap_raddr,
  input  logic [DATA_W-1:0] ofmap_rdata,
  output logic              valid,
  output logic [DATA_W-1:0] ofmap,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LD_IF    = 3'd1;
  localparam logic [2:0] S_LD_W     = 3'd2;
  localparam logic [2:0] S_LD_B     = 3'd3;
  localparam logic [2:0] S_WAIT_CMP = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  localparam logic [IF_AW-1:0] IF_LAST = IF_AW'(IFMAP_WORDS - 1);
  localparam logic [W_AW-1:0]  W_LAST  = W_AW'(WEIGHT_WORDS - 1);
  localparam logic [B_AW-1:0]  B_LAST  = B_AW'(BIAS_WORDS - 1);
  localparam logic [O_AW-1:0]  O_LAST  = O_AW'(OFMAP_WORDS - 1);

  logic [2:0]       state;
  logic [IF_AW-1:0] if_cnt;
  logic [W_AW-1:0]  w_cnt;
  logic [B_AW-1:0]  b_cnt;
  logic [O_AW-1:0]  rd_cnt;
  logic             re_d;

  // Reads are issued straight from the read counter so the SRAM sees them in the first DRAIN cycle.
  assign ofmap_re    = (state == S_DRAIN);
  assign ofmap_raddr = rd_cnt;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      if_cnt      <= '0;
      w_cnt       <= '0;
      b_cnt       <= '0;
      rd_cnt      <= '0;
      re_d        <= 1'b0;
      ifmap_we    <= 1'b0;
      ifmap_addr  <= '0;
      weight_we   <= 1'b0;
      weight_addr <= '0;
      bias_we     <= 1'b0;
      bias_addr   <= '0;
      wdata       <= '0;
      load_done   <= 1'b0;
      valid       <= 1'b0;
      ofmap       <= '0;
      done        <= 1'b0;
    end else begin
      ifmap_we  <= 1'b0;
      weight_we <= 1'b0;
      bias_we   <= 1'b0;
      load_done <= 1'b0;
      done      <= 1'b0;
      // SRAM data lags the read by one cycle, so the returned word is captured behind re_d.
      re_d      <= ofmap_re;
      valid     <= re_d;
      if (re_d) ofmap <= ofmap_rdata;

      case (state)
        S_IDLE: begin
          if (ready) state <= S_LD_IF;
        end
        S_LD_IF: begin
          ifmap_we   <= 1'b1;
          ifmap_addr <= if_cnt;
          wdata      <= data_in;
          if (if_cnt == IF_LAST) begin
            if_cnt <= '0;
            state  <= S_LD_W;
          end else begin
            if_cnt <= if_cnt + 1'b1;
          end
        end
        S_LD_W: begin
          weight_we   <= 1'b1;
          weight_addr <= w_cnt;
          wdata       <= data_in;
          if (w_cnt == W_LAST) begin
            w_cnt <= '0;
            state <= S_LD_B;
          end else begin
            w_cnt <= w_cnt + 1'b1;
          end
        end
        S_LD_B: begin
          bias_we   <= 1'b1;
          bias_addr <= b_cnt;
          wdata     <= data_in;
          if (b_cnt == B_LAST) begin
            b_cnt     <= '0;
            load_done <= 1'b1;
            state     <= S_WAIT_CMP;
          end else begin
            b_cnt <= b_cnt + 1'b1;
          end
        end
        S_WAIT_CMP: begin
          if (compute_done) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (rd_cnt == O_LAST) begin
            rd_cnt <= '0;
            state  <= S_FIN;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        S_FIN: begin
          // Hold FIN until the last word has gone out, then show done for one cycle.
          if (done) begin
            state <= S_IDLE;
          end else if (valid && !re_d) begin
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_stream_if.sv
// Bench for host_stream_if: streams full passes, checks every write and drained word
// against a position-based model, plus reset-abort and spurious-control sequences.
module tb_host_stream_if;

  localparam int IFW   = 16;
  localparam int WW    = 1024;
  localparam int BW    = 64;
  localparam int OW    = 64;
  localparam int TOTAL = IFW + WW + BW;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] data_in;
  logic        compute_done;
  logic        ifmap_we;
  logic [3:0]  ifmap_addr;
  logic        weight_we;
  logic [9:0]  weight_addr;
  logic        bias_we;
  logic [5:0]  bias_addr;
  logic [31:0] wdata;
  logic        load_done;
  logic        ofmap_re;
  logic [5:0]  ofmap_raddr;
  logic [31:0] ofmap_rdata = 32'd0;
  logic        valid;
  logic [31:0] ofmap;
  logic        busy;
  logic        done;

  logic [31:0] ofmap_base = 32'd0;
  int n_cmp = 0;
  int n_bad = 0;

  host_stream_if dut (
    .clk(clk), .rst(rst), .ready(ready), .data_in(data_in), .compute_done(compute_done),
    .ifmap_we(ifmap_we), .ifmap_addr(ifmap_addr), .weight_we(weight_we),
    .weight_addr(weight_addr), .bias_we(bias_we), .bias_addr(bias_addr), .wdata(wdata),
    .load_done(load_done), .ofmap_re(ofmap_re), .ofmap_raddr(ofmap_raddr),
    .ofmap_rdata(ofmap_rdata), .valid(valid), .ofmap(ofmap), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Ofmap SRAM model: one-cycle read latency, contents = base + address.
  always @(posedge clk) begin
    if (ofmap_re) ofmap_rdata <= ofmap_base + 32'(ofmap_raddr);
  end

  typedef struct {
    int         k;
    logic [2:0] sel;
    int         addr;
    logic       ld;
  } vec_t;

  vec_t vec_tab[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero();
    check_output("rst_ctrl", 64'({ifmap_we, ifmap_addr, weight_we, weight_addr, bias_we, bias_addr,
                                  load_done, ofmap_re, ofmap_raddr, valid, done, busy}), 64'd0);
    check_output("rst_data", {wdata, ofmap}, 64'd0);
  endtask

  // Stream position alone decides the target SRAM and its address.
  task automatic expected_write(input int k, output logic [2:0] sel, output int addr);
    if (k < IFW) begin
      sel  = 3'b100;
      addr = k;
    end else if (k < IFW + WW) begin
      sel  = 3'b010;
      addr = k - IFW;
    end else begin
      sel  = 3'b001;
      addr = k - IFW - WW;
    end
  endtask

  function automatic int act_addr(input logic [2:0] sel);
    case (sel)
      3'b100:  return int'(ifmap_addr);
      3'b010:  return int'(weight_addr);
      3'b001:  return int'(bias_addr);
      default: return -1;
    endcase
  endfunction

  task automatic apply_stimulus(input bit rand_data, input int load_abort, input int drain_abort,
                                input bit use_table);
    logic [31:0] words[$];
    logic [2:0]  esel;
    int          eaddr;
    int          nwait;
    words.delete();
    for (int k = 0; k < TOTAL; k++) words.push_back(rand_data ? $urandom : 32'(k));
    ofmap_base = rand_data ? $urandom : 32'hA000_0000;

    check_output("idle_before", 64'({busy, valid}), 64'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check_output("ld_start", 64'({ifmap_we, weight_we, bias_we, busy}), 64'b0001);

    for (int k = 0; k < TOTAL; k++) begin
      data_in      = words[k];
      ready        = (k == IFW + 200);
      compute_done = (k == 3);
      if (k == load_abort) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero();
        return;
      end
      tick();
      ready        = 1'b0;
      compute_done = 1'b0;
      expected_write(k, esel, eaddr);
      check_output("we_sel", 64'({ifmap_we, weight_we, bias_we}), 64'(esel));
      check_output("waddr", 64'(act_addr(esel)), 64'(eaddr));
      check_output("wdata", 64'(wdata), 64'(words[k]));
      check_output("load_done", 64'(load_done), 64'(k == TOTAL - 1));
      check_output("load_flags", 64'({busy, valid, ofmap_re}), 64'b100);
      if (use_table) begin
        for (int t = 0; t < 8; t++) begin
          if (vec_tab[t].k == k) begin
            check_output("tab_sel", 64'({ifmap_we, weight_we, bias_we}), 64'(vec_tab[t].sel));
            check_output("tab_addr", 64'(act_addr(vec_tab[t].sel)), 64'(vec_tab[t].addr));
            check_output("tab_wdata", 64'(wdata), 64'(k));
            check_output("tab_ld", 64'(load_done), 64'(vec_tab[t].ld));
          end
        end
      end
    end

    nwait = $urandom_range(1, 6);
    for (int i = 0; i < nwait; i++) begin
      ready = (i == 0);
      tick();
      ready = 1'b0;
      check_output("wait_cmp", 64'({ifmap_we, weight_we, bias_we, load_done, ofmap_re, valid, busy}),
                   64'b0000001);
    end

    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
    for (int c = 0; c <= OW + 3; c++) begin
      if (c == drain_abort) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero();
        return;
      end
      check_output("ofmap_re", 64'(ofmap_re), 64'(c < OW));
      if (c < OW) check_output("raddr", 64'(ofmap_raddr), 64'(c));
      check_output("valid", 64'(valid), 64'(c >= 2 && c <= OW + 1));
      if (c >= 2 && c <= OW + 1) check_output("ofmap", 64'(ofmap), 64'(ofmap_base + 32'(c - 2)));
      check_output("done", 64'(done), 64'(c == OW + 2));
      check_output("busy", 64'(busy), 64'(c <= OW + 2));
      check_output("drain_we", 64'({ifmap_we, weight_we, bias_we}), 64'd0);
      if (c < OW + 3) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_tab[0] = '{0,    3'b100, 0,    1'b0};
    vec_tab[1] = '{15,   3'b100, 15,   1'b0};
    vec_tab[2] = '{16,   3'b010, 0,    1'b0};
    vec_tab[3] = '{17,   3'b010, 1,    1'b0};
    vec_tab[4] = '{1039, 3'b010, 1023, 1'b0};
    vec_tab[5] = '{1040, 3'b001, 0,    1'b0};
    vec_tab[6] = '{1102, 3'b001, 62,   1'b0};
    vec_tab[7] = '{1103, 3'b001, 63,   1'b1};

    rst          = 1'b1;
    ready        = 1'b0;
    compute_done = 1'b0;
    data_in      = 32'd0;
    repeat (3) tick();
    check_zero();
    rst = 1'b0;
    tick();
    check_zero();

    compute_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("idle_spurious", 64'({busy, ofmap_re, valid, ifmap_we, weight_we, bias_we}), 64'd0);
    end
    compute_done = 1'b0;

    apply_stimulus(1'b0, -1, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("between", 64'({busy, valid}), 64'd0);
    end
    apply_stimulus(1'b1, -1, -1, 1'b0);
    apply_stimulus(1'b1, IFW + 500, -1, 1'b0);
    apply_stimulus(1'b1, -1, 30, 1'b0);
    apply_stimulus(1'b1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
